// File: rtl/aes_key_expansion_if.sv
// AES-128 key-schedule request/read bundle shared by the controller and the expander.
// Latency: n/a (wires only).
// Backpressure: none; start is a level sampled by the expander, reads are free-running.
interface aes_key_expansion_if;
    logic         key_start_in;
    logic [127:0] cipher_key_in;
    logic [3:0]   round_sel_in;
    logic [127:0] round_key_out;
    logic         key_ready_out;
    logic         busy_out;

    modport master (
        output key_start_in, cipher_key_in, round_sel_in,
        input  round_key_out, key_ready_out, busy_out
    );

    modport slave (
        input  key_start_in, cipher_key_in, round_sel_in,
        output round_key_out, key_ready_out, busy_out
    );
endinterface

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: expands the cipher key into 11 stored round keys, one per cycle.
// Latency: key_ready 10 cycles after the accepted start edge; round-key reads 1 cycle.
// Backpressure: none; start is ignored while expanding, reads are always served.

// Byte S-box: forward (en_or_de=1) or inverse (en_or_de=0), computed as GF(2^8) inverse + affine map.
module sbox_combi (
    input  logic       en_or_de,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    logic [7:0] inv_v;
    logic [7:0] pre_v;

    // Forward: invert then affine; inverse: inverse-affine then invert.
    always_comb begin
        inv_v    = 8'h00;
        pre_v    = 8'h00;
        data_out = 8'h00;
        if (en_or_de) begin
            inv_v    = ginv(data_in);
            data_out = inv_v ^ rotl(inv_v, 1) ^ rotl(inv_v, 2) ^ rotl(inv_v, 3)
                     ^ rotl(inv_v, 4) ^ 8'h63;
        end else begin
            pre_v    = rotl(data_in, 1) ^ rotl(data_in, 3) ^ rotl(data_in, 6) ^ 8'h05;
            data_out = ginv(pre_v);
        end
    end
endmodule

module aes_key_expansion #(
    parameter int NR = 10
) (
    input logic              clk,
    input logic              reset_n,
    aes_key_expansion_if.slave kif
);
    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         ready_q, ready_d;
    logic         busy_q, busy_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] key_q [0:NR];

    logic         wr_en;
    logic [3:0]   wr_idx;
    logic [127:0] wr_dat;
    logic [3:0]   prev_idx;
    logic [127:0] prev_key;
    logic [31:0]  rot_w, sub_w, t_w;
    logic [31:0]  q0, q1, q2, q3;

    // Previous round key and the next one derived from it (RotWord, SubWord, Rcon, XOR chain).
    always_comb begin
        prev_idx = cnt_q - 4'd1;
        prev_key = '0;
        if (cnt_q != 4'd0 && prev_idx <= LAST) prev_key = key_q[prev_idx];
    end

    assign rot_w = {prev_key[23:0], prev_key[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sub
        sbox_combi u_sbox (
            .en_or_de (1'b1),
            .data_in  (rot_w[8*g +: 8]),
            .data_out (sub_w[8*g +: 8])
        );
    end

    assign t_w = sub_w ^ {rcon_q, 24'h0};
    assign q0  = prev_key[127:96] ^ t_w;
    assign q1  = prev_key[95:64]  ^ q0;
    assign q2  = prev_key[63:32]  ^ q1;
    assign q3  = prev_key[31:0]   ^ q2;

    // Next-state, key-store write and read-mux selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rcon_d  = rcon_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        wr_en   = 1'b0;
        wr_idx  = cnt_q;
        wr_dat  = {q0, q1, q2, q3};
        rk_d    = '0;
        if (kif.round_sel_in <= LAST) rk_d = key_q[kif.round_sel_in];
        case (state_q)
            IDLE, DONE: begin
                if (kif.key_start_in) begin
                    wr_en   = 1'b1;
                    wr_idx  = 4'd0;
                    wr_dat  = kif.cipher_key_in;
                    cnt_d   = 4'd1;
                    rcon_d  = 8'h01;
                    state_d = EXPAND;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end
            EXPAND: begin
                wr_en  = 1'b1;
                cnt_d  = cnt_q + 4'd1;
                rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rcon_q  <= 8'h01;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            rk_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcon_q  <= rcon_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            rk_q    <= rk_d;
        end
    end

    // Round-key store: one entry written per cycle while loading or expanding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= NR; i++) key_q[i] <= '0;
        end else if (wr_en && wr_idx <= LAST) begin
            key_q[wr_idx] <= wr_dat;
        end
    end

    assign kif.round_key_out = rk_q;
    assign kif.key_ready_out = ready_q;
    assign kif.busy_out      = busy_q;
endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed bench for the AES-128 key schedule using FIPS-197 and all-zero key vectors.
// Latency: checks ready 10 cycles after start and 1-cycle read latency.
// Backpressure: none; every wait is cycle-bounded.
module tb_aes_key_expansion;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_ZERO = 128'h0;

    aes_key_expansion_if kif ();

    aes_key_expansion #(.NR(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kif     (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         zero_key;
        logic [3:0]   sel;
        logic [127:0] exp;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic read_key(input logic [3:0] sel, output logic [127:0] d);
        @(negedge clk);
        kif.round_sel_in = sel;
        @(negedge clk);
        d = kif.round_key_out;
    endtask

    task automatic run_table(input logic zero_key);
        logic [127:0] d;
        foreach (vt[i]) begin
            if (vt[i].zero_key == zero_key) begin
                read_key(vt[i].sel, d);
                chk($sformatf("%s_rk%0d", zero_key ? "zero" : "a1", vt[i].sel), d, vt[i].exp);
            end
        end
    endtask

    // Drives start across one rising edge; returns at the following falling edge with start still high.
    task automatic start_key(input logic [127:0] key);
        @(negedge clk);
        kif.cipher_key_in = key;
        kif.key_start_in  = 1'b1;
        @(negedge clk);
    endtask

    // Counts busy cycles until ready, dropping start after 'hold' further cycles.
    task automatic wait_done(input int hold, output int nbusy);
        bit done;
        nbusy = 0;
        done  = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (i == hold) kif.key_start_in = 1'b0;
            if (kif.key_ready_out) begin
                done = 1'b1;
            end else begin
                if (kif.busy_out) nbusy++;
                @(negedge clk);
            end
        end
        kif.key_start_in = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
    endtask

    initial begin
        logic [127:0] d;
        int           nb;
        checks = 0;
        errors = 0;

        vt.push_back('{1'b0, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c});
        vt.push_back('{1'b0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605});
        vt.push_back('{1'b0, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f});
        vt.push_back('{1'b0, 4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b});
        vt.push_back('{1'b0, 4'd4,  128'hef44a541a8525b7fb671253bdb0bad00});
        vt.push_back('{1'b0, 4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc});
        vt.push_back('{1'b0, 4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd});
        vt.push_back('{1'b0, 4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f});
        vt.push_back('{1'b0, 4'd8,  128'head27321b58dbad2312bf5607f8d292f});
        vt.push_back('{1'b0, 4'd9,  128'hac7766f319fadc2128d12941575c006e});
        vt.push_back('{1'b0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
        vt.push_back('{1'b1, 4'd0,  128'h0});
        vt.push_back('{1'b1, 4'd1,  128'h62636363626363636263636362636363});
        vt.push_back('{1'b1, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e});

        kif.key_start_in  = 1'b0;
        kif.cipher_key_in = '0;
        kif.round_sel_in  = '0;
        reset_n           = 1'b1;
        #3 reset_n = 1'b0;
        #2;
        chk("reset_ready", {127'h0, kif.key_ready_out}, 128'h0);
        chk("reset_busy",  {127'h0, kif.busy_out},      128'h0);
        chk("reset_rk",    kif.round_key_out,           128'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // FIPS-197 A.1 key, single-cycle start.
        start_key(KEY_A1);
        wait_done(0, nb);
        chk("a1_busy_cycles", 128'(nb), 128'd10);
        chk("a1_ready", {127'h0, kif.key_ready_out}, 128'h1);
        chk("a1_busy_low", {127'h0, kif.busy_out}, 128'h0);
        run_table(1'b0);

        // Out-of-range indices read as zero.
        for (int s = 11; s < 16; s++) begin
            read_key(4'(s), d);
            chk($sformatf("oor_sel%0d", s), d, 128'h0);
        end

        // Start held high into EXPAND with a changed key: must not restart.
        start_key(KEY_A1);
        kif.cipher_key_in = KEY_ZERO;
        wait_done(5, nb);
        chk("hold_busy_cycles", 128'(nb), 128'd10);
        run_table(1'b0);

        // Back-to-back restart with the zero key from DONE.
        start_key(KEY_ZERO);
        chk("restart_ready_drop", {127'h0, kif.key_ready_out}, 128'h0);
        chk("restart_busy_high",  {127'h0, kif.busy_out},      128'h1);
        wait_done(0, nb);
        chk("zero_busy_cycles", 128'(nb), 128'd10);
        chk("zero_ready", {127'h0, kif.key_ready_out}, 128'h1);
        run_table(1'b1);

        // Asynchronous reset while the counter is at 5.
        start_key(KEY_A1);
        kif.key_start_in = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_ready", {127'h0, kif.key_ready_out}, 128'h0);
        chk("midrst_busy",  {127'h0, kif.busy_out},      128'h0);
        chk("midrst_rk",    kif.round_key_out,           128'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int s = 0; s < 11; s++) begin
            read_key(4'(s), d);
            chk($sformatf("postrst_rk%0d", s), d, 128'h0);
        end
        chk("postrst_ready", {127'h0, kif.key_ready_out}, 128'h0);
        chk("postrst_busy",  {127'h0, kif.busy_out},      128'h0);
        start_key(KEY_A1);
        wait_done(0, nb);
        chk("rerun_busy_cycles", 128'(nb), 128'd10);
        run_table(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_key_expansion.md
Name: aes_key_expansion

Overview:
Generates the AES-128 key schedule feeding the aes_encryption round engine's key_in.
- On start, it loads the 128-bit cipher key and computes round keys 1..10 iteratively, one per cycle.
- It holds all 11 round keys in an internal register file.
- It serves any round key by index, so the controller can drive round_in and round_sel_in from the same round counter.

Parameters:
NR, 10, number of AES rounds; only 10 (AES-128) supported, other values out of scope.

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
key_start_in  input  1  request expansion of cipher_key_in; sampled in IDLE or DONE only
cipher_key_in  input  128  cipher key; [127:96] = word w0, [31:0] = w3; sampled on accepted start edge only
round_sel_in  input  4  round key index 0..10 to read
round_key_out  output  128  registered round key for round_sel_in (1-cycle read latency)
key_ready_out  output  1  high while all 11 round keys are valid
busy_out  output  1  high while expansion in progress

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE; key_ready_out=0; busy_out=0; round_key_out=0.
  - Round counter=0; rcon=8'h01; all 11 key-store entries = 0.
- States: IDLE, EXPAND, DONE.
- IDLE/DONE with key_start_in=1 at edge N:
  - key[0] <= cipher_key_in; counter <= 1; rcon <= 8'h01.
  - state <= EXPAND; busy_out <= 1; key_ready_out <= 0.
- IDLE/DONE with key_start_in=0: hold state and stored keys.
- EXPAND, one round key per edge (edges N+1..N+10):
  - prev = key[counter-1] = {p0,p1,p2,p3}; p3 = {b0,b1,b2,b3}.
  - t = SubWord({b1,b2,b3,b0}) ^ {rcon,24'h0}.
  - q0=p0^t; q1=p1^q0; q2=p2^q1; q3=p3^q2.
  - key[counter] <= {q0,q1,q2,q3}; counter++.
  - rcon <= xtime(rcon): shift left 1, XOR 8'h1B if bit7 was set. Sequence 01,02,04,08,10,20,40,80,1B,36.
- Edge N+10 (counter==10):
  - Store key[10]; state <= DONE; busy_out <= 0; key_ready_out <= 1.
  - key_ready_out is first visible after edge N+10.
- SubWord uses 4 instances of sbox_combi with en_or_de=1 (forward S-box). Purely combinational within the EXPAND cycle.
- key_start_in during EXPAND: ignored; expansion continues unchanged.
- key_start_in in DONE: restart. key_ready_out drops on the accept edge; old keys 1..10 are overwritten progressively.
- Read path, every edge in all states:
  - round_key_out <= key[round_sel_in] if round_sel_in <= 10, else 128'h0.
  - Reads during EXPAND return current store contents; these are valid only for indices already written.
- Consumer rule: use round_key_out only while key_ready_out=1. Present round_sel_in one cycle before the key is needed.
- Reset mid-EXPAND: all state and store cleared as above; a fresh key_start_in is required.
- No combinational path from any input to any output.

Test Plan:
1. FIPS-197 A.1 key:
   - Stimulus: cipher_key_in=2b7e151628aed2a6abf7158809cf4f3c, 1-cycle start pulse.
   - Response: busy_out high for exactly 10 cycles; key_ready_out rises 10 edges after the start edge.
   - Reads: round_sel_in=0 -> 2b7e1516...cf4f3c; round_sel_in=1 -> a0fafe1788542cb123a339392a6c7605; round_sel_in=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6, each 1 cycle after round_sel_in is applied.
2. All-zero key:
   - round 1 -> 62636363626363636263636362636363.
   - round 10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
3. Out-of-range and start handling:
   - round_sel_in=11..15 in DONE -> round_key_out=0.
   - key_start_in held high for 5 cycles mid-EXPAND -> no restart; test-1 keys unchanged; ready timing unchanged.
4. Back-to-back restart:
   - Start with the zero key while in DONE after test 1.
   - key_ready_out low the next cycle, high again 10 edges later; round 10 reads b4ef5bcb....
5. Reset mid-operation:
   - Assert reset_n low asynchronously at EXPAND counter=5.
   - Outputs are 0 immediately.
   - After release, all indices read 0 until a new start. A new start with the A.1 key reproduces test-1 values.
